// File: rtl/port_avail_tracker.sv
// Output-port availability tracker for the 4-port deflection router.
// Keeps a busy countdown per port, publishes a registered free-port mask with
// its popcount, and flags malformed or conflicting port claims one cycle later.
module port_avail_tracker #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned CW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NPORT-1:0] claimA,
  input  logic [NPORT-1:0] claimB,
  input  logic [NPORT-1:0] linkStall,
  output logic [NPORT-1:0] availMask,
  output logic [2:0]       availCnt,
  output logic             atLeastTwo,
  output logic             claimErr,
  output logic [NPORT-1:0] errPort
);

  localparam logic [CW-1:0] HoldVal = CW'(HOLD);

  logic [CW-1:0]    cnt_q [NPORT];
  logic [CW-1:0]    cnt_d [NPORT];
  logic [NPORT-1:0] claim;
  logic [NPORT-1:0] valid;
  logic [NPORT-1:0] mask_d;
  logic [2:0]       popcnt_d;
  logic             multi_a;
  logic             multi_b;
  logic [NPORT-1:0] err_bits;

  // Per-port countdown, next free mask and its popcount.
  always_comb begin
    claim    = claimA | claimB;
    // A port can only be granted if it was advertised free this cycle.
    valid    = claim & availMask;
    popcnt_d = 3'd0;
    for (int i = 0; i < NPORT; i++) begin
      if (valid[i]) begin
        cnt_d[i] = HoldVal;
      end else if ((cnt_q[i] != '0) && !linkStall[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      mask_d[i] = (cnt_d[i] == '0) && !linkStall[i];
      popcnt_d  = popcnt_d + 3'(mask_d[i]);
    end
  end

  // Violation detection: multi-bit vectors, A/B overlap, claims on busy ports.
  always_comb begin
    // v & (v-1) is nonzero exactly when more than one bit is set.
    multi_a  = (claimA & (claimA - 1'b1)) != '0;
    multi_b  = (claimB & (claimB - 1'b1)) != '0;
    err_bits = (claimA & claimB) | (claim & ~availMask);
    if (multi_a) err_bits = err_bits | claimA;
    if (multi_b) err_bits = err_bits | claimB;
  end

  // Counter and output registers; reset frees every port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPORT; i++) cnt_q[i] <= '0;
      availMask  <= '1;
      availCnt   <= 3'(NPORT);
      atLeastTwo <= 1'b1;
      claimErr   <= 1'b0;
      errPort    <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) cnt_q[i] <= cnt_d[i];
      availMask  <= mask_d;
      availCnt   <= popcnt_d;
      atLeastTwo <= popcnt_d >= 3'd2;
      claimErr   <= err_bits != '0;
      errPort    <= err_bits;
    end
  end

endmodule

// File: tb/tb_port_avail_tracker.sv
// Directed bench for port_avail_tracker with hand-computed expectations.
module tb_port_avail_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] claimA;
  logic [3:0] claimB;
  logic [3:0] linkStall;
  logic [3:0] availMask;
  logic [2:0] availCnt;
  logic       atLeastTwo;
  logic       claimErr;
  logic [3:0] errPort;

  int checks = 0;
  int errors = 0;

  port_avail_tracker #(.NPORT(4), .HOLD(2), .CW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .claimA     (claimA),
    .claimB     (claimB),
    .linkStall  (linkStall),
    .availMask  (availMask),
    .availCnt   (availCnt),
    .atLeastTwo (atLeastTwo),
    .claimErr   (claimErr),
    .errPort    (errPort)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] m, input logic [2:0] c,
                         input logic two, input logic err, input logic [3:0] ep);
    chk({tag, ".mask"}, {4'b0, availMask}, {4'b0, m});
    chk({tag, ".cnt"}, {5'b0, availCnt}, {5'b0, c});
    chk({tag, ".two"}, {7'b0, atLeastTwo}, {7'b0, two});
    chk({tag, ".err"}, {7'b0, claimErr}, {7'b0, err});
    chk({tag, ".eport"}, {4'b0, errPort}, {4'b0, ep});
  endtask

  initial begin
    // Reset with a claim held: reset wins.
    reset = 1'b1; claimA = 4'b0100; claimB = 4'b0000; linkStall = 4'b0000;
    step(); step();
    chk_all("rst", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);
    reset = 1'b0; claimA = 4'b0000;
    step();
    chk_all("post_rst", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);

    // Stall on an idle port masks it only.
    linkStall = 4'b1000;
    step();
    chk_all("idle_stall", 4'b0111, 3'd3, 1'b1, 1'b0, 4'b0000);
    linkStall = 4'b0000;
    step();
    chk_all("idle_unstall", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);

    // Two clean claims, HOLD = 2.
    claimA = 4'b1000; claimB = 4'b0010;
    step();
    claimA = 4'b0000; claimB = 4'b0000;
    chk_all("dual_t1", 4'b0101, 3'd2, 1'b1, 1'b0, 4'b0000);
    step();
    chk_all("dual_t2", 4'b0101, 3'd2, 1'b1, 1'b0, 4'b0000);
    step();
    chk_all("dual_t3", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);

    // Stall extends busy window by two cycles.
    claimA = 4'b0001;
    step();
    claimA = 4'b0000; linkStall = 4'b0001;
    chk("stall_t1", {4'b0, availMask}, 8'h0e);
    step();
    chk("stall_t2", {4'b0, availMask}, 8'h0e);
    step();
    linkStall = 4'b0000;
    chk("stall_t3", {4'b0, availMask}, 8'h0e);
    step();
    chk("stall_t4", {4'b0, availMask}, 8'h0e);
    step();
    chk("stall_t5", {4'b0, availMask}, 8'h0f);

    // Claim on busy port 2: error, countdown not reloaded.
    claimA = 4'b0100;
    step();
    claimA = 4'b0000; claimB = 4'b0100;
    chk_all("busy_t1", 4'b1011, 3'd3, 1'b1, 1'b0, 4'b0000);
    step();
    claimB = 4'b0000;
    chk_all("busy_err", 4'b1011, 3'd3, 1'b1, 1'b1, 4'b0100);
    step();
    chk_all("busy_clr", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);

    // Overlapping claims on a free port: granted and flagged.
    claimA = 4'b0001; claimB = 4'b0001;
    step();
    claimA = 4'b0000; claimB = 4'b0000;
    chk_all("ovl_t1", 4'b1110, 3'd3, 1'b1, 1'b1, 4'b0001);
    step();
    chk_all("ovl_t2", 4'b1110, 3'd3, 1'b1, 1'b0, 4'b0000);
    step();
    chk_all("ovl_t3", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);

    // Non-one-hot claim: every free bit granted and flagged.
    claimA = 4'b0110;
    step();
    claimA = 4'b0000;
    chk_all("multi_t1", 4'b1001, 3'd2, 1'b1, 1'b1, 4'b0110);
    step();
    chk_all("multi_t2", 4'b1001, 3'd2, 1'b1, 1'b0, 4'b0000);
    step();
    chk_all("multi_t3", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);

    // Three busy ports over two cycles.
    claimA = 4'b0001; claimB = 4'b0010;
    step();
    claimA = 4'b0100; claimB = 4'b0000;
    chk_all("three_t1", 4'b1100, 3'd2, 1'b1, 1'b0, 4'b0000);
    step();
    claimA = 4'b1000;
    chk_all("three_t2", 4'b1000, 3'd1, 1'b0, 1'b0, 4'b0000);
    // Claim while atLeastTwo == 0 is not an error by itself.
    step();
    claimA = 4'b0000;
    chk_all("low_claim", 4'b0011, 3'd2, 1'b1, 1'b0, 4'b0000);

    // Reset mid-busy frees all ports.
    reset = 1'b1; claimB = 4'b0001;
    step();
    reset = 1'b0; claimB = 4'b0000;
    chk_all("mid_rst", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);
    step();
    chk_all("mid_rst_idle", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
